// File: rtl/he_lut_mapper.sv
// -----------------------------------------------------------------------------
// he_lut_mapper
//
// Reader side of the cumulative histogram bank. When start is pulsed, the block
// walks the CDF through a synchronous read port and records cdf_min, the first
// nonzero cumulative count. It then builds a 2^PixelSize-entry equalization LUT:
//     LUT[i] = (cdf[i] - cdf_min) * (2^PixelSize - 1) / (TotalPixels - cdf_min)
// After the LUT is built, the block remaps the incoming pixel stream through it.
//
// Parameters
//   PixelSize    bits per pixel; the LUT has 2^PixelSize entries
//   TotalPixels  pixel count per frame (N)
//   histoWidth   width of the CDF values; must be able to hold TotalPixels
//
// Optional feature
//   HE_ROUND_EN  when defined, the divider numerator becomes num + (den>>1),
//                which gives round-half-up. When undefined, the quotient is
//                truncated.
//
// Ports
//   clk                   clock
//   rst                   asynchronous, active-high reset
//   start                 single-cycle pulse that begins a LUT build; ignored
//                         while busy
//   cdf_rd_en             CDF read strobe
//   cdf_rd_addr           gray level being read; holds its value between strobes
//   cdf_rd_data           CDF value, valid exactly one cycle after the strobe
//   busy                  high while FIND_MIN / BUILD are in progress
//   lut_ready             LUT valid; mapping enabled
//   pixel_data_in         pixel to remap
//   pixel_data_valid      qualifies pixel_data_in
//   pixel_data_out        equalized pixel (1-cycle latency)
//   pixel_data_out_valid  qualifies pixel_data_out
// -----------------------------------------------------------------------------
module he_lut_mapper #(
  parameter int PixelSize   = 8,
  parameter int TotalPixels = 640*480,
  parameter int histoWidth  = $clog2(640*480)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  cdf_rd_en,
  output logic [PixelSize-1:0]  cdf_rd_addr,
  input  logic [histoWidth-1:0] cdf_rd_data,
  output logic                  busy,
  output logic                  lut_ready,
  input  logic [PixelSize-1:0]  pixel_data_in,
  input  logic                  pixel_data_valid,
  output logic [PixelSize-1:0]  pixel_data_out,
  output logic                  pixel_data_out_valid
);

  localparam int LEVELS = 1 << PixelSize;
  // Divider working width: num, plus the optional rounding term, stays below
  // 2^PixelSize * den, so one bit of headroom over histoWidth+PixelSize is enough.
  localparam int DW     = histoWidth + PixelSize + 1;
  localparam int BCW    = $clog2(PixelSize + 1);

  localparam logic [histoWidth-1:0] TP_W       = histoWidth'(TotalPixels);
  localparam logic [PixelSize-1:0]  LAST_LEVEL = {PixelSize{1'b1}};
  localparam logic [BCW-1:0]        LAST_BIT   = BCW'(PixelSize - 1);

  // S_MIN_RD / S_MIN_CHK form FIND_MIN. S_RD .. S_WR form BUILD, which takes
  // PixelSize+3 cycles per level.
  typedef enum logic [2:0] {
    S_IDLE,
    S_MIN_RD,
    S_MIN_CHK,
    S_RD,
    S_PREP,
    S_DIV,
    S_WR,
    S_MAP
  } state_t;

  state_t                  state_reg,     state_next;
  logic                    rd_en_reg,     rd_en_next;
  logic [PixelSize-1:0]    rd_addr_reg,   rd_addr_next;   // also the current level
  logic                    busy_reg,      busy_next;
  logic                    ready_reg,     ready_next;
  logic [histoWidth-1:0]   cdf_min_reg,   cdf_min_next;
  logic [histoWidth-1:0]   den_reg,       den_next;
  logic [DW-1:0]           rem_reg,       rem_next;
  logic [DW-1:0]           dsh_reg,       dsh_next;       // shifted divisor
  logic [PixelSize-1:0]    quo_reg,       quo_next;
  logic [BCW-1:0]          bit_cnt_reg,   bit_cnt_next;
  logic                    out_valid_reg, out_valid_next;
  logic [PixelSize-1:0]    pixel_out_reg;

  logic                    launch;
  logic                    map_fire;
  logic                    lut_we;
  logic [PixelSize-1:0]    lut_wdata;
  logic [histoWidth-1:0]   diff;
  logic [DW-1:0]           num;

  logic [PixelSize-1:0]    lut_mem [LEVELS];

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    rd_en_next     = 1'b0;
    rd_addr_next   = rd_addr_reg;
    busy_next      = busy_reg;
    ready_next     = ready_reg;
    cdf_min_next   = cdf_min_reg;
    den_next       = den_reg;
    rem_next       = rem_reg;
    dsh_next       = dsh_reg;
    quo_next       = quo_reg;
    bit_cnt_next   = bit_cnt_reg;
    launch         = 1'b0;
    map_fire       = 1'b0;
    lut_we         = 1'b0;
    lut_wdata      = quo_reg;
    diff           = '0;
    num            = '0;

    unique case (state_reg)
      S_IDLE: begin
        if (start) launch = 1'b1;
      end

      S_MIN_RD: begin
        state_next = S_MIN_CHK;
      end

      S_MIN_CHK: begin
        if (cdf_rd_data != '0 || rd_addr_reg == LAST_LEVEL) begin
          // If all levels are empty, cdf_min is left at 0, which is the data
          // value here anyway.
          cdf_min_next = cdf_rd_data;
          state_next   = S_RD;
          rd_en_next   = 1'b1;
          rd_addr_next = '0;
        end else begin
          state_next   = S_MIN_RD;
          rd_en_next   = 1'b1;
          rd_addr_next = rd_addr_reg + PixelSize'(1);
        end
      end

      S_RD: begin
        state_next = S_PREP;
      end

      S_PREP: begin
        // Zeros that come before the first nonzero level read below cdf_min.
        // They clamp to 0 so that the difference does not wrap.
        if (cdf_rd_data > cdf_min_reg) diff = cdf_rd_data - cdf_min_reg;
        // diff * (2^PixelSize - 1) computed as a shift and a subtract.
        num      = (DW'(diff) << PixelSize) - DW'(diff);
        den_next = (cdf_min_reg < TP_W) ? (TP_W - cdf_min_reg) : '0;
`ifdef HE_ROUND_EN
        rem_next = num + DW'(den_next >> 1);
`else
        rem_next = num;
`endif
        dsh_next     = DW'(den_next) << (PixelSize - 1);
        quo_next     = '0;
        bit_cnt_next = '0;
        state_next   = S_DIV;
      end

      S_DIV: begin
        // Restoring division, one quotient bit per cycle, MSB first.
        if (rem_reg >= dsh_reg) begin
          rem_next = rem_reg - dsh_reg;
          quo_next = {quo_reg[PixelSize-2:0], 1'b1};
        end else begin
          quo_next = {quo_reg[PixelSize-2:0], 1'b0};
        end
        dsh_next     = dsh_reg >> 1;
        bit_cnt_next = bit_cnt_reg + BCW'(1);
        if (bit_cnt_reg == LAST_BIT) state_next = S_WR;
      end

      S_WR: begin
        lut_we    = 1'b1;
        // With den == 0 (a flat image), the divider output has no meaning.
        lut_wdata = (den_reg == '0) ? '0 : quo_reg;
        if (rd_addr_reg == LAST_LEVEL) begin
          busy_next  = 1'b0;
          ready_next = 1'b1;
          state_next = S_MAP;
        end else begin
          state_next   = S_RD;
          rd_en_next   = 1'b1;
          rd_addr_next = rd_addr_reg + PixelSize'(1);
        end
      end

      S_MAP: begin
        // A start pulse aborts mapping. The pixel in that same cycle is not
        // emitted.
        if (start)                 launch   = 1'b1;
        else if (pixel_data_valid) map_fire = 1'b1;
      end

      default: state_next = S_IDLE;
    endcase

    if (launch) begin
      state_next   = S_MIN_RD;
      rd_en_next   = 1'b1;
      rd_addr_next = '0;
      busy_next    = 1'b1;
      ready_next   = 1'b0;
    end

    out_valid_next = map_fire;
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      rd_en_reg     <= 1'b0;
      rd_addr_reg   <= '0;
      busy_reg      <= 1'b0;
      ready_reg     <= 1'b0;
      cdf_min_reg   <= '0;
      den_reg       <= '0;
      rem_reg       <= '0;
      dsh_reg       <= '0;
      quo_reg       <= '0;
      bit_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rd_en_reg     <= rd_en_next;
      rd_addr_reg   <= rd_addr_next;
      busy_reg      <= busy_next;
      ready_reg     <= ready_next;
      cdf_min_reg   <= cdf_min_next;
      den_reg       <= den_next;
      rem_reg       <= rem_next;
      dsh_reg       <= dsh_next;
      quo_reg       <= quo_next;
      bit_cnt_reg   <= bit_cnt_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // ---------------------------------------------------------------------------
  // LUT storage. It has no reset, and a new build overwrites every entry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (lut_we) lut_mem[rd_addr_reg] <= lut_wdata;
  end

  // Registered read port. When no pixel is accepted, the output holds its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pixel_out_reg <= '0;
    else if (map_fire) pixel_out_reg <= lut_mem[pixel_data_in];
  end

  assign cdf_rd_en            = rd_en_reg;
  assign cdf_rd_addr          = rd_addr_reg;
  assign busy                 = busy_reg;
  assign lut_ready            = ready_reg;
  assign pixel_data_out       = pixel_out_reg;
  assign pixel_data_out_valid = out_valid_reg;

endmodule
